uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of uart_tx. Samples an asynchronous serial line (8N1, LSB first, idle high) and delivers each received byte on an AXI-stream master interface. Uses the same cycles_per_bit parameterisation as uart_tx, so one value configures both ends of a link.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// frame width and the mid-bit offset used to centre sampling.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int half_bit_cycles(input int cycles_per_bit);
    return cycles_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. RESET_VAL sets the
// value both flops take in reset so the output matches the input's idle level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with an AXI-stream byte output. Defining
// UART_RX_ERR_STATUS_EN adds framing_err and overflow pulse outputs.
module uart_rx
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tready,
  output logic                 tvalid,
  output logic [DATA_BITS-1:0] tdata
`ifdef UART_RX_ERR_STATUS_EN
  ,
  output logic                 framing_err,
  output logic                 overflow
`endif
);

  localparam int CW = $clog2(cycles_per_bit);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_bit_cycles(cycles_per_bit) - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(cycles_per_bit - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  // Handshake: tvalid/tdata hold until a cycle with tvalid && tready; a byte
  // completing while the held byte is stalled is dropped, and one completing
  // on the handshake cycle itself replaces it with tvalid kept high.

  uart_rx_state_t       state;
  logic [CW-1:0]        bit_cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 wrap;
  logic                 byte_done;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign wrap      = (bit_cnt == BIT_LAST);
  assign byte_done = (state == STOP) && wrap && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      idx     <= '0;
      shift   <= '0;
      tvalid  <= 1'b0;
      tdata   <= '0;
`ifdef UART_RX_ERR_STATUS_EN
      framing_err <= 1'b0;
      overflow    <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_ERR_STATUS_EN
      framing_err <= 1'b0;
      overflow    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end
        START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (wrap) begin
            bit_cnt    <= '0;
            shift[idx] <= rx_s;
            idx        <= idx + 1'b1;
            if (idx == IDX_LAST) state <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            bit_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state <= BREAK;
`ifdef UART_RX_ERR_STATUS_EN
              framing_err <= 1'b1;
`endif
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (byte_done) begin
        if (!tvalid || tready) begin
          tdata  <= shift;
          tvalid <= 1'b1;
        end else begin
`ifdef UART_RX_ERR_STATUS_EN
          overflow <= 1'b1;
`endif
        end
      end else if (tvalid && tready) begin
        tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a short bit period; covers error pulses when
// built with UART_RX_ERR_STATUS_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tready = 1'b1;
  logic       tvalid;
  logic [7:0] tdata;
`ifdef UART_RX_ERR_STATUS_EN
  logic       framing_err;
  logic       overflow;
`endif

  uart_rx #(.cycles_per_bit(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .tready (tready),
    .tvalid (tvalid),
    .tdata  (tdata)
`ifdef UART_RX_ERR_STATUS_EN
    ,
    .framing_err (framing_err),
    .overflow    (overflow)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;
  logic tvalid_q = 1'b0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic hold_watch = 1'b0;
  int hold_bad = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) got_q.push_back(tdata);
      if (tvalid && !tvalid_q && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hold_watch && tvalid && !tready && tdata !== 8'h12) hold_bad++;
`ifdef UART_RX_ERR_STATUS_EN
      if (framing_err) fe_cnt++;
      if (overflow) ov_cnt++;
`endif
    end
    tvalid_q = tvalid;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_val);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop_val);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic sample_point();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] burst[7] = '{8'hC3, 8'h00, 8'hFF, 8'h7E, 8'h01, 8'h80, 8'h9A};

  initial begin
    repeat (4) @(negedge clk);
    sample_point();
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 8'h00);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // single byte and its latency from the raw start edge
    first_valid_cyc = -1;
    send_frame(8'h55, 1'b1);
    exp_q.push_back(8'h55);
    idle(2 * CPB);
    sample_point();
    compare_rx("single");
    check("latency", first_valid_cyc - start_cyc, 3 + CPB / 2 + 9 * CPB);

    // back-to-back burst
    @(negedge clk);
    foreach (burst[i]) begin
      send_frame(burst[i], 1'b1);
      exp_q.push_back(burst[i]);
    end
    idle(2 * CPB);
    sample_point();
    compare_rx("burst");

    // start-bit glitch shorter than half a bit
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clk);
    idle(3 * CPB);
    sample_point();
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    compare_rx("glitch");

    // framing error, held break, then a good byte
    @(negedge clk);
    fe_cnt = 0;
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    idle(CPB);
    send_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    idle(2 * CPB);
    sample_point();
    compare_rx("framing");
`ifdef UART_RX_ERR_STATUS_EN
    check("framing_err_pulses", fe_cnt, 1);
`endif

    // overflow while the sink stalls
    @(negedge clk);
    ov_cnt = 0;
    tready = 1'b0;
    hold_bad = 0;
    hold_watch = 1'b1;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(CPB);
    sample_point();
    check("ovf_tvalid_held", tvalid, 1'b1);
    check("ovf_tdata_held", tdata, 8'h12);
    @(negedge clk);
    hold_watch = 1'b0;
    tready = 1'b1;
    exp_q.push_back(8'h12);
    idle(2 * CPB);
    sample_point();
    check("ovf_hold_stable", hold_bad, 0);
    compare_rx("overflow");
`ifdef UART_RX_ERR_STATUS_EN
    check("overflow_pulses", ov_cnt, 1);
`endif

    // reset during bit 3 of 8'hFF, then a clean frame
    @(negedge clk);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(CPB);
    sample_point();
    check("abort_tvalid", tvalid, 1'b0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    send_frame(8'h81, 1'b1);
    exp_q.push_back(8'h81);
    idle(2 * CPB);
    sample_point();
    compare_rx("after_rst");

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
